// File: rtl/dma_loopback_arbiter.sv
// dma_loopback_arbiter
//   Round-robin arbiter that lets NCH AXI-Stream requester channels take
//   turns driving one shared stream into a loopback tester. Ownership is
//   packet-granular: once a channel is granted, it keeps the stream until
//   its tlast beat has been accepted.
//
// Ports
//   tester_clk, tester_resetn : clock (rising edge), async active-low reset
//   arb_en                    : allow new arbitration picks
//   ch_mask[NCH]              : per-channel grant enable
//   s_tvalid/s_tready/s_tdata/s_tkeep/s_tlast : packed per-channel slave streams
//   m_tvalid/m_tready/m_tdata/m_tkeep/m_tlast/m_tdest : shared master stream
//   grant[NCH]                : one-hot current owner, zero when idle
//   pkt_done                  : one-cycle pulse after each completed packet
//   pkt_cnt[16]               : wrapping count of completed packets
module dma_loopback_arbiter #(
  parameter int DW  = 32,
  parameter int NCH = 4
) (
  input  logic                  tester_clk,
  input  logic                  tester_resetn,
  input  logic                  arb_en,
  input  logic [NCH-1:0]        ch_mask,
  input  logic [NCH-1:0]        s_tvalid,
  output logic [NCH-1:0]        s_tready,
  input  logic [NCH*DW-1:0]     s_tdata,
  input  logic [NCH*DW/8-1:0]   s_tkeep,
  input  logic [NCH-1:0]        s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DW-1:0]         m_tdata,
  output logic [DW/8-1:0]       m_tkeep,
  output logic                  m_tlast,
  output logic [3:0]            m_tdest,
  output logic [NCH-1:0]        grant,
  output logic                  pkt_done,
  output logic [15:0]           pkt_cnt
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NCH-1:0]  grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   last_q, last_d;
  logic            pkt_done_q, pkt_done_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;

  logic [NCH-1:0]  req;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand_idx;
  int unsigned     cand;

  logic            sel_valid;
  logic [DW-1:0]   sel_data;
  logic [DW/8-1:0] sel_keep;
  logic            sel_last;
  logic            busy;
  logic            end_beat;

  // Round-robin search: first requesting channel starting one past the
  // previous owner, wrapping around.
  always_comb begin
    req      = s_tvalid & ch_mask;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand     = (32'(last_q) + 32'd1 + k) % NCH;
      cand_idx = IW'(cand);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // Granted-channel select.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gidx_q == IW'(i)) begin
        sel_valid = s_tvalid[i];
        sel_data  = s_tdata[i*DW +: DW];
        sel_keep  = s_tkeep[i*(DW/8) +: DW/8];
        sel_last  = s_tlast[i];
      end
    end
  end

  assign busy     = (state_q == BUSY);
  assign m_tvalid = busy & sel_valid;
  assign m_tdata  = busy ? sel_data : '0;
  assign m_tkeep  = busy ? sel_keep : '0;
  assign m_tlast  = busy & sel_last;
  assign s_tready = busy ? (NCH'(m_tready) << gidx_q) : '0;
  assign end_beat = m_tvalid & m_tready & m_tlast;

  assign grant    = grant_q;
  assign m_tdest  = 4'(gidx_q);
  assign pkt_done = pkt_done_q;
  assign pkt_cnt  = pkt_cnt_q;

  // Next-state: arb_en and ch_mask only matter for the IDLE pick, so an
  // in-flight packet is unaffected by either.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    pkt_done_d = 1'b0;
    pkt_cnt_d  = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_en && pick_vld) begin
          state_d = BUSY;
          grant_d = NCH'(1) << pick_idx;
          gidx_d  = pick_idx;
        end
      end
      BUSY: begin
        if (end_beat) begin
          state_d    = IDLE;
          grant_d    = '0;
          last_d     = gidx_q;
          pkt_done_d = 1'b1;
          pkt_cnt_d  = pkt_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge tester_clk or negedge tester_resetn) begin
    if (!tester_resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_q     <= IW'(NCH - 1);
      pkt_done_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      pkt_done_q <= pkt_done_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_dma_loopback_arbiter.sv
// Directed bench for dma_loopback_arbiter (DW=32, NCH=4).
// Each channel source sends npkts[c] packets of len[c] beats; beat data is
// {channel, packet number, beat number} so the output can be checked by hand.
module tb_dma_loopback_arbiter;

  localparam int DW  = 32;
  localparam int NCH = 4;

  logic              tester_clk;
  logic              tester_resetn;
  logic              arb_en;
  logic [NCH-1:0]    ch_mask;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH*4-1:0]  s_tkeep;
  logic [NCH-1:0]    s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [3:0]        m_tkeep;
  logic              m_tlast;
  logic [3:0]        m_tdest;
  logic [NCH-1:0]    grant;
  logic              pkt_done;
  logic [15:0]       pkt_cnt;

  int errors = 0;
  int checks = 0;

  int unsigned len   [NCH];
  int unsigned npkts [NCH];
  int unsigned sent  [NCH];
  int unsigned beat  [NCH];

  dma_loopback_arbiter #(.DW(DW), .NCH(NCH)) dut (
    .tester_clk    (tester_clk),
    .tester_resetn (tester_resetn),
    .arb_en        (arb_en),
    .ch_mask       (ch_mask),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .s_tlast       (s_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tlast       (m_tlast),
    .m_tdest       (m_tdest),
    .grant         (grant),
    .pkt_done      (pkt_done),
    .pkt_cnt       (pkt_cnt)
  );

  initial tester_clk = 1'b0;
  always #5 tester_clk = ~tester_clk;

  function automatic logic [31:0] beat_data(input int unsigned c, p, b);
    return {8'(c), 8'(p), 16'(b)};
  endfunction

  // Channel sources
  always_comb begin
    s_tvalid = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = '0;
    for (int c = 0; c < NCH; c++) begin
      s_tvalid[c]         = (sent[c] < npkts[c]);
      s_tlast[c]          = (beat[c] + 1 == len[c]);
      s_tdata[c*DW +: DW] = beat_data(c, sent[c], beat[c]);
      s_tkeep[c*4 +: 4]   = s_tlast[c] ? 4'h7 : 4'hF;
    end
  end

  always @(posedge tester_clk or negedge tester_resetn) begin
    if (!tester_resetn) begin
      for (int c = 0; c < NCH; c++) beat[c] <= 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (s_tvalid[c] && s_tready[c]) begin
          if (s_tlast[c]) begin
            beat[c] <= 0;
            sent[c] <= sent[c] + 1;
          end else begin
            beat[c] <= beat[c] + 1;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance on falling edges until a grant appears, then check it.
  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    while (grant == '0 && n < 40) begin
      @(negedge tester_clk);
      n++;
    end
    check(tag, 32'(grant), 32'(exp));
  endtask

  // Advance until the grant drops; the done pulse must be visible then.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (grant != '0 && n < 40) begin
      @(negedge tester_clk);
      n++;
    end
    check({tag, "_idle"}, 32'(grant), 32'h0);
    check({tag, "_done"}, 32'(pkt_done), 32'h1);
  endtask

  logic [3:0] exp_g [5];
  int         b;
  bit         done;
  int         n;

  initial begin
    for (int c = 0; c < NCH; c++) begin
      len[c] = 1; npkts[c] = 0; sent[c] = 0;
    end
    tester_resetn = 1'b0;
    arb_en   = 1'b1;
    ch_mask  = 4'hF;
    m_tready = 1'b1;

    // Reset values
    @(negedge tester_clk);
    check("rst_grant",    32'(grant),    32'h0);
    check("rst_mvalid",   32'(m_tvalid), 32'h0);
    check("rst_sready",   32'(s_tready), 32'h0);
    check("rst_pkt_cnt",  32'(pkt_cnt),  32'h0);
    check("rst_pkt_done", 32'(pkt_done), 32'h0);
    check("rst_tdest",    32'(m_tdest),  32'h0);

    // All four channels, 2-beat packets; channel 0 has a second packet
    for (int c = 0; c < NCH; c++) len[c] = 2;
    npkts[0] = 2; npkts[1] = 1; npkts[2] = 1; npkts[3] = 1;
    @(negedge tester_clk);
    tester_resetn = 1'b1;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("rr_grant%0d", k), exp_g[k]);
      check($sformatf("rr_tdest%0d", k), 32'(m_tdest), (k == 4) ? 32'd0 : 32'(k));
      wait_idle($sformatf("rr_pkt%0d", k));
      if (k == 3) check("rr_cnt4", 32'(pkt_cnt), 32'd4);
    end

    // Channel 1, 5 beats, m_tready toggling 1,0,1,0...
    len[1] = 5; npkts[1] = sent[1] + 1;
    wait_grant("stall_grant", 4'b0010);
    b = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      check("stall_hold",   32'(grant),             32'h2);
      check("stall_others", 32'(s_tready & 4'b1101), 32'h0);
      if (m_tvalid && m_tready) begin
        check($sformatf("stall_data%0d", b), m_tdata, 32'h0101_0000 + 32'(b));
        check($sformatf("stall_last%0d", b), 32'(m_tlast), (b == 4) ? 32'h1 : 32'h0);
        if (b == 4) begin
          check("stall_keep", 32'(m_tkeep), 32'h7);
          done = 1;
        end
        b++;
      end
      if (!done) begin
        m_tready = ~m_tready;
        @(negedge tester_clk);
      end
    end
    m_tready = 1'b1;
    check("stall_beats", 32'(b), 32'd5);
    wait_idle("stall");

    // Mask 1010: only 1 and 3, alternating, starting after channel 1
    ch_mask = 4'b1010;
    for (int c = 0; c < NCH; c++) begin
      len[c] = 1; npkts[c] = sent[c] + 2;
    end
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("mask_grant%0d", k), exp_g[k]);
      wait_idle($sformatf("mask_pkt%0d", k));
    end
    npkts[0] = sent[0]; npkts[2] = sent[2];
    ch_mask = 4'hF;

    // arb_en drops during beat 2 of a 4-beat packet on channel 2
    len[2] = 4; npkts[2] = sent[2] + 3;
    wait_grant("en_grant", 4'b0100);
    check("en_tdest", 32'(m_tdest), 32'd2);
    @(negedge tester_clk);
    arb_en = 1'b0;
    wait_idle("en_pkt");
    check("en_cnt", 32'(pkt_cnt), 32'd11);
    for (int k = 0; k < 4; k++) begin
      @(negedge tester_clk);
      check($sformatf("en_off%0d", k), 32'(grant), 32'h0);
    end
    npkts[2] = sent[2];
    arb_en = 1'b1;

    // Reset on beat 3 of a channel-3 packet; channels 0 and 1 also waiting
    len[0] = 1; len[1] = 1; len[3] = 4;
    npkts[0] = sent[0] + 1; npkts[1] = sent[1] + 1; npkts[3] = sent[3] + 1;
    wait_grant("mrst_grant", 4'b1000);
    @(negedge tester_clk);
    @(negedge tester_clk);
    tester_resetn = 1'b0;
    #1;
    check("mrst_grant0",  32'(grant),    32'h0);
    check("mrst_mvalid",  32'(m_tvalid), 32'h0);
    check("mrst_sready",  32'(s_tready), 32'h0);
    check("mrst_cnt",     32'(pkt_cnt),  32'h0);
    check("mrst_done",    32'(pkt_done), 32'h0);
    check("mrst_tdest",   32'(m_tdest),  32'h0);
    @(negedge tester_clk);
    @(negedge tester_clk);
    tester_resetn = 1'b1;
    wait_grant("mrst_first", 4'b0001);
    check("mrst_cnt_after", 32'(pkt_cnt), 32'h0);
    n = 0;
    while (n < 80 && !(grant == '0 && sent[0] >= npkts[0] && sent[1] >= npkts[1]
                       && sent[3] >= npkts[3])) begin
      @(negedge tester_clk);
      n++;
    end
    check("mrst_drain", 32'(grant), 32'h0);
    check("mrst_cnt3",  32'(pkt_cnt), 32'd3);

    // Channel 2 alone, back-to-back single-beat packets
    len[2] = 1; npkts[2] = sent[2] + 3;
    wait_grant("solo_first", 4'b0100);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("solo_grant%0d", k), 32'(grant), 32'h4);
      @(negedge tester_clk);
      check($sformatf("solo_gap%0d", k),  32'(grant),    32'h0);
      check($sformatf("solo_done%0d", k), 32'(pkt_done), 32'h1);
      @(negedge tester_clk);
    end
    check("solo_cnt", 32'(pkt_cnt), 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
